// File: rtl/conv_ctrl.sv
// conv_ctrl: convolution sequencer (im2col reset, weight/im2col fetch, systolic feed, result writeback).
// Defining CONV_CTRL_PERF_EN adds the perf_cycles busy-cycle counter output.
module conv_ctrl #(
  parameter int unsigned           M           = 20,
  parameter int unsigned           N           = 9,
  parameter int unsigned           K           = 5,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 32'h1000,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 32'h2000,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = 32'h3000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        rst_im2col,
  input  logic                        im2col_done,
  output logic                        rst_systolic,
  output logic [DATA_WIDTH*N-1:0]     X,
  output logic [DATA_WIDTH*N*K-1:0]   W,
  input  logic [DATA_WIDTH*K-1:0]     Y,
  input  logic                        Y_valid,
  output logic [ADDR_WIDTH-1:0]       addr_rd,
  input  logic [DATA_WIDTH-1:0]       data_rd,
  output logic [ADDR_WIDTH-1:0]       addr_wr,
  output logic [DATA_WIDTH-1:0]       data_wr,
  output logic                        mem_wr_en
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [31:0]                 perf_cycles
`endif
);

  localparam int unsigned NK  = N * K;
  localparam int unsigned MN  = M * N;
  localparam int unsigned MK  = M * K;
  localparam int unsigned CW  = $clog2(MN + 1);
  localparam int unsigned RW  = $clog2(M + 1);
  localparam int unsigned WIW = $clog2(NK);
  localparam int unsigned XIW = $clog2(MN);
  localparam int unsigned RIW = $clog2(MK);

  typedef enum logic [2:0] {IDLE, IM2COL, LOAD_W, LOAD_X, RUN, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           idx_q, idx_d, idx_inc;
  logic [RW-1:0]           feed_q, feed_d, cap_q, cap_d;
  logic                    cap_en_q, cap_en_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    rst_im2col_q, rst_im2col_d, rst_sys_q, rst_sys_d;
  logic [DATA_WIDTH*N-1:0] x_q, x_d, row_sel;
  logic [ADDR_WIDTH-1:0]   addr_rd_q, addr_rd_d, addr_wr_q, addr_wr_d;
  logic [DATA_WIDTH-1:0]   data_wr_q, data_wr_d;
  logic                    wr_en_q, wr_en_d;
  logic                    w_we, xb_we, res_we;

  logic [DATA_WIDTH-1:0]   w_q    [NK];
  logic [DATA_WIDTH-1:0]   xbuf_q [MN];
  logic [DATA_WIDTH-1:0]   res_q  [MK];

  assign idx_inc = idx_q + CW'(1);

  always_comb begin
    row_sel = '0;
    if (feed_q < RW'(M))
      for (int unsigned j = 0; j < N; j++)
        row_sel[j*DATA_WIDTH +: DATA_WIDTH] = xbuf_q[XIW'(32'(feed_q) * N + j)];
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    feed_d       = feed_q;
    cap_d        = cap_q;
    cap_en_d     = cap_en_q;
    rst_im2col_d = rst_im2col_q;
    rst_sys_d    = rst_sys_q;
    x_d          = x_q;
    addr_rd_d    = addr_rd_q;
    addr_wr_d    = addr_wr_q;
    data_wr_d    = data_wr_q;
    wr_en_d      = 1'b0;
    w_we         = 1'b0;
    xb_we        = 1'b0;
    res_we       = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d      = IM2COL;
        rst_im2col_d = 1'b0;
      end
      IM2COL: if (im2col_done) begin
        state_d   = LOAD_W;
        idx_d     = '0;
        feed_d    = '0;
        addr_rd_d = WEIGHT_BASE;
      end
      // Reads are pipelined: cycle idx captures the word addressed in cycle idx-1.
      LOAD_W: begin
        idx_d = idx_inc;
        w_we  = (idx_q != '0);
        if (idx_q < CW'(NK - 1)) addr_rd_d = WEIGHT_BASE + ADDR_WIDTH'(idx_inc);
        if (idx_q == CW'(NK)) begin
          state_d   = LOAD_X;
          idx_d     = '0;
          addr_rd_d = IM2COL_BASE;
        end
      end
      LOAD_X: begin
        idx_d = idx_inc;
        xb_we = (idx_q != '0);
        if (idx_q < CW'(MN - 1)) addr_rd_d = IM2COL_BASE + ADDR_WIDTH'(idx_inc);
        if (idx_q == CW'(MN)) begin
          state_d   = RUN;
          rst_sys_d = 1'b0;
          x_d       = row_sel;
          feed_d    = RW'(1);
          cap_en_d  = 1'b0;
          cap_d     = '0;
        end
      end
      RUN: begin
        x_d = row_sel;
        if (feed_q < RW'(M)) feed_d = feed_q + RW'(1);
        if (Y_valid) begin
          cap_d    = '0;
          cap_en_d = 1'b1;
        end else if (cap_en_q) begin
          res_we = 1'b1;
          cap_d  = cap_q + RW'(1);
          if (cap_q == RW'(M - 1)) begin
            state_d   = WRITE;
            cap_en_d  = 1'b0;
            x_d       = '0;
            idx_d     = '0;
            wr_en_d   = 1'b1;
            addr_wr_d = OUTPUT_BASE;
            data_wr_d = res_q[0];
          end
        end
      end
      WRITE: begin
        idx_d   = idx_inc;
        wr_en_d = 1'b1;
        if (idx_q == CW'(MK - 1)) begin
          state_d   = DONE;
          wr_en_d   = 1'b0;
          rst_sys_d = 1'b1;
        end else begin
          addr_wr_d = OUTPUT_BASE + ADDR_WIDTH'(idx_inc);
          data_wr_d = res_q[RIW'(idx_inc)];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = !(state_d == IDLE || state_d == DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      feed_q       <= '0;
      cap_q        <= '0;
      cap_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rst_im2col_q <= 1'b1;
      rst_sys_q    <= 1'b1;
      x_q          <= '0;
      addr_rd_q    <= '0;
      addr_wr_q    <= '0;
      data_wr_q    <= '0;
      wr_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      feed_q       <= feed_d;
      cap_q        <= cap_d;
      cap_en_q     <= cap_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rst_im2col_q <= rst_im2col_d;
      rst_sys_q    <= rst_sys_d;
      x_q          <= x_d;
      addr_rd_q    <= addr_rd_d;
      addr_wr_q    <= addr_wr_d;
      data_wr_q    <= data_wr_d;
      wr_en_q      <= wr_en_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NK; i++) w_q[i] <= '0;
    end else if (w_we) begin
      w_q[WIW'(idx_q - CW'(1))] <= data_rd;
    end
  end

  // Row and result buffers are always fully rewritten before being consumed.
  always_ff @(posedge clk) begin
    if (xb_we) xbuf_q[XIW'(idx_q - CW'(1))] <= data_rd;
    if (res_we)
      for (int unsigned k = 0; k < K; k++)
        res_q[RIW'(32'(cap_q) * K + k)] <= Y[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    for (int unsigned i = 0; i < NK; i++) W[i*DATA_WIDTH +: DATA_WIDTH] = w_q[i];
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rst_im2col   = rst_im2col_q;
  assign rst_systolic = rst_sys_q;
  assign X            = x_q;
  assign addr_rd      = addr_rd_q;
  assign addr_wr      = addr_wr_q;
  assign data_wr      = data_wr_q;
  assign mem_wr_en    = wr_en_q;

`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else if (start && (state_q == IDLE || state_q == DONE)) perf_q <= '0;
    else if (busy_q) perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule
